// File: rtl/prog_loader8_if.sv
// prog_loader8_if: program stream, RAM write port, CPU control and status bundle
interface prog_loader8_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 3,
  parameter int CYC_W   = 32
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic               restart;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [7:0]         ram_wdata;
  logic [INSTR_W-1:0] cpu_instr;
  logic               cpu_enable;
  logic               done;
  logic               error;
  logic [ADDR_W:0]    byte_count;
  logic [CYC_W-1:0]   run_cycles;
  modport master (
    output in_data, in_valid, in_last, restart, cpu_instr,
    input  in_ready, ram_we, ram_addr, ram_wdata, cpu_enable, done, error, byte_count, run_cycles
  );
  modport slave (
    input  in_data, in_valid, in_last, restart, cpu_instr,
    output in_ready, ram_we, ram_addr, ram_wdata, cpu_enable, done, error, byte_count, run_cycles
  );
endinterface

// File: rtl/prog_loader8.sv
// prog_loader8: streams a program into CPU RAM, runs the CPU until it halts, reports counts
module prog_loader8 #(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 3,
  parameter int HALT_COUNT = 4,
  parameter int CYC_W      = 32
) (
  input logic clk,
  input logic rst,
  prog_loader8_if.slave bus
);
  localparam int ZW = $clog2(HALT_COUNT + 1);
  typedef enum logic [2:0] {LOAD, COMMIT, RUN, HALTED, ERROR} state_t;
  state_t state, nstate;
  logic [ADDR_W-1:0] ptr;
  logic [ZW-1:0] zcnt;
  logic accept, zero, clear;
  assign bus.in_ready = (state == LOAD) & ~rst;
  assign accept = bus.in_valid & bus.in_ready;
  assign zero = bus.cpu_instr == '0;
  assign clear = bus.restart & ((state == HALTED) | (state == ERROR));
  always_ff @(posedge clk)
    state <= rst ? LOAD : nstate;
  always_comb begin
    nstate = state;
    case (state)
      LOAD:    nstate = !accept ? LOAD : bus.in_last ? COMMIT : (&ptr) ? ERROR : LOAD;
      COMMIT:  nstate = RUN;
      RUN:     nstate = (zero && zcnt == ZW'(HALT_COUNT - 1)) ? HALTED : RUN;
      default: nstate = bus.restart ? LOAD : state;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      ptr            <= '0;
      zcnt           <= '0;
      bus.ram_we     <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_wdata  <= '0;
      bus.cpu_enable <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
      bus.byte_count <= '0;
      bus.run_cycles <= '0;
    end else begin
      bus.ram_we <= accept;
      if (accept) begin
        bus.ram_addr   <= ptr;
        bus.ram_wdata  <= bus.in_data;
        ptr            <= ptr + 1'b1;
        bus.byte_count <= bus.byte_count + 1'b1;
      end
      if (state == RUN) begin
        bus.run_cycles <= (&bus.run_cycles) ? bus.run_cycles : bus.run_cycles + 1'b1;
        zcnt           <= zero ? zcnt + 1'b1 : zcnt;
      end
      if (clear) begin
        ptr            <= '0;
        zcnt           <= '0;
        bus.byte_count <= '0;
        bus.run_cycles <= '0;
      end
      bus.cpu_enable <= nstate == RUN;
      bus.done       <= nstate == HALTED;
      bus.error      <= nstate == ERROR;
    end
endmodule

// File: tb/tb_prog_loader8.sv
// tb_prog_loader8: directed load/run scenarios with a scoreboard on the RAM write port
module tb_prog_loader8;
  logic clk = 0, rst = 1;
  int tests = 0, fails = 0;
  logic [15:0] q[$];
  logic [7:0] wp;
  prog_loader8_if #(.ADDR_W(8), .INSTR_W(3), .CYC_W(32)) bus();
  prog_loader8 #(.ADDR_W(8), .INSTR_W(3), .HALT_COUNT(4), .CYC_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic last);
    bus.in_valid = 1;
    bus.in_data = d;
    bus.in_last = last;
    chk("in_ready_load", bus.in_ready, 1);
    q.push_back({wp, d});
    wp++;
    tick;
    bus.in_valid = 0;
    bus.in_last = 0;
  endtask
  always @(negedge clk)
    if (bus.ram_we) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.ram_addr, bus.ram_wdata);
      end else chk("ram_write", {bus.ram_addr, bus.ram_wdata}, q.pop_front());
    end
  initial begin
    logic [2:0] pat [7];
    logic [7:0] bytes5 [5];
    pat = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0};
    bytes5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.in_last = 0;
    bus.restart = 0;
    bus.cpu_instr = 3'd1;
    wp = 0;
    repeat (3) tick;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_cpu_enable", bus.cpu_enable, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_byte_count", bus.byte_count, 0);
    chk("rst_run_cycles", bus.run_cycles, 0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 5; i++) send(bytes5[i], i == 4);
    chk("commit_enable", bus.cpu_enable, 0);
    chk("commit_in_ready", bus.in_ready, 0);
    chk("bc5", bus.byte_count, 5);
    tick;
    chk("run_enable", bus.cpu_enable, 1);
    for (int i = 0; i < 7; i++) begin
      bus.cpu_instr = pat[i];
      chk("run_enable_hold", bus.cpu_enable, 1);
      chk("run_in_ready", bus.in_ready, 0);
      tick;
    end
    bus.cpu_instr = 3'd5;
    chk("halt_enable", bus.cpu_enable, 0);
    chk("halt_done", bus.done, 1);
    chk("halt_run_cycles", bus.run_cycles, 7);
    tick;
    chk("halt_hold_cycles", bus.run_cycles, 7);
    chk("halt_hold_bc", bus.byte_count, 5);
    bus.restart = 1;
    bus.in_valid = 1;
    bus.in_data = 8'hAA;
    chk("restart_in_ready", bus.in_ready, 0);
    tick;
    bus.restart = 0;
    bus.in_valid = 0;
    chk("restart_done", bus.done, 0);
    chk("restart_bc", bus.byte_count, 0);
    chk("restart_cycles", bus.run_cycles, 0);
    chk("restart_in_ready_load", bus.in_ready, 1);
    wp = 0;
    for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A, i == 255);
    chk("full_last_error", bus.error, 0);
    chk("full_last_bc", bus.byte_count, 256);
    chk("full_commit_in_ready", bus.in_ready, 0);
    chk("full_commit_enable", bus.cpu_enable, 0);
    tick;
    chk("full_run_enable", bus.cpu_enable, 1);
    bus.cpu_instr = 3'd2;
    repeat (10) tick;
    chk("run10_cycles", bus.run_cycles, 10);
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("midrun_rst_enable", bus.cpu_enable, 0);
    chk("midrun_rst_cycles", bus.run_cycles, 0);
    chk("midrun_rst_in_ready", bus.in_ready, 1);
    wp = 0;
    send(8'hC1, 0);
    send(8'hC2, 1);
    tick;
    chk("two_bc", bus.byte_count, 2);
    chk("two_enable", bus.cpu_enable, 1);
    bus.cpu_instr = 3'd0;
    repeat (3) tick;
    chk("two_not_halted", bus.done, 0);
    tick;
    chk("two_halted", bus.done, 1);
    chk("two_cycles", bus.run_cycles, 4);
    bus.cpu_instr = 3'd1;
    bus.restart = 1;
    tick;
    bus.restart = 0;
    wp = 0;
    for (int i = 0; i < 256; i++) send(8'(255 - i), 0);
    chk("ovf_error", bus.error, 1);
    chk("ovf_bc", bus.byte_count, 256);
    chk("ovf_in_ready", bus.in_ready, 0);
    chk("ovf_enable", bus.cpu_enable, 0);
    bus.in_valid = 1;
    repeat (3) tick;
    bus.in_valid = 0;
    chk("ovf_enable_hold", bus.cpu_enable, 0);
    chk("ovf_error_hold", bus.error, 1);
    chk("ovf_done", bus.done, 0);
    bus.restart = 1;
    tick;
    bus.restart = 0;
    chk("ovf_restart_error", bus.error, 0);
    chk("ovf_restart_bc", bus.byte_count, 0);
    repeat (2) tick;
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prog_loader8.md
Name: prog_loader8

Overview:
- Hardware program loader and run controller for byteblast8; sits directly upstream of the CPU.
- Accepts a program as a valid/ready byte stream and writes it sequentially into CPU RAM from address 0.
- Then asserts the CPU enable and watches the decoded instruction for the halt condition (opcode 000).
- On halt it drops enable and reports done, the loaded byte count and the run-cycle count.

Parameters:
- ADDR_W, 8, RAM address width; MEM_DEPTH = 2**ADDR_W.
- INSTR_W, 3, width of the CPU instruction field observed for halt.
- HALT_COUNT, 4, number of RUN cycles with instr==0 required before halting (min 1).
- CYC_W, 32, width of the run-cycle counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  8  program byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks final program byte; qualified by in_valid.
- in_ready  out  1  loader accepts a byte this cycle.
- restart  in  1  single-cycle request to reload after HALTED/ERROR.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM write address.
- ram_wdata  out  8  RAM write data.
- cpu_instr  in  INSTR_W  CPU control-unit current instruction.
- cpu_enable  out  1  CPU enable.
- done  out  1  program halted normally.
- error  out  1  program exceeded MEM_DEPTH without in_last.
- byte_count  out  ADDR_W+1  bytes written in last load.
- run_cycles  out  CYC_W  enabled CPU cycles in last run, saturating.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs while rst is high: in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_enable=0, done=0, error=0, byte_count=0, run_cycles=0.
  - Internal state: state=LOAD, write pointer=0, zero counter=0.
  - Reset mid-LOAD or mid-RUN aborts immediately; RAM contents are not cleared.
- States: LOAD, COMMIT, RUN, HALTED, ERROR.
- LOAD:
  - in_ready=1 (combinational decode of state, 0 while rst).
  - Accept when in_valid&in_ready at an edge. The RAM write port is registered: during the next cycle ram_we=1, ram_addr=pointer, ram_wdata=byte. The pointer and byte_count increment at the accepting edge.
  - If ram_we is not driven by a new accept, it returns to 0.
  - Accept with in_last=1 -> COMMIT.
  - Accept with in_last=0 at pointer==MEM_DEPTH-1 -> ERROR; that byte is still written.
  - in_last at pointer==MEM_DEPTH-1 is legal and goes to COMMIT; byte_count=MEM_DEPTH.
- COMMIT: one cycle, in_ready=0, final write in progress -> RUN.
- RUN:
  - cpu_enable=1 (registered; high from the edge leaving COMMIT). run_cycles increments each RUN edge, saturating at all-ones.
  - Each edge with cpu_instr==0 increments the zero counter. The counter is cumulative and does not clear on nonzero instructions.
  - The edge on which the count reaches HALT_COUNT -> HALTED; cpu_enable=0 and done=1 from that edge.
  - in_valid is ignored (in_ready=0).
- HALTED / ERROR:
  - cpu_enable=0, in_ready=0. done=1 in HALTED; error=1 in ERROR.
  - byte_count and run_cycles hold.
  - restart=1 -> LOAD at next edge. Pointer, zero counter, byte_count, run_cycles, done and error all clear.
  - restart is ignored in LOAD/COMMIT/RUN.
- rst has priority over restart and over any handshake in the same cycle.

Test Plan:
- Load 5 bytes 0x11,0x22,0x33,0x44,0x55 (last on 0x55), cpu_instr held nonzero -> RAM writes addr 0..4 with matching data, one cycle after each accept; byte_count=5; cpu_enable rises 2 cycles after the last accept.
- After load, drive cpu_instr=0 for one cycle, nonzero 3 cycles, then 0 every cycle -> cpu_enable falls on the 4th zero-instr edge; done=1; run_cycles=7.
- Stream 256 bytes with in_last never asserted -> 256 writes (addr 0..255), error=1, byte_count=256, cpu_enable never asserted, in_ready=0 afterward.
- Exactly 256 bytes with in_last on the 256th -> no error; COMMIT then RUN; byte_count=256.
- Assert rst for one cycle while in RUN after 10 cycles -> next cycle cpu_enable=0, run_cycles=0, in_ready=1; a fresh 2-byte load writes addr 0,1.
- From HALTED, pulse restart concurrently with in_valid -> no byte accepted that cycle; done clears; the next byte is written to addr 0.
